axis_bram_writer: RTL

AXIS_BRAM_WRITER -- requirements
Module: axis_bram_writer

---
 rtl/axis_bram_writer_pkg.sv | 16 +
 rtl/axis_bram_writer_if.sv | 27 ++
 rtl/axis_bram_writer.sv | 113 +++++++++++
 3 files changed

// File: rtl/axis_bram_writer_pkg.sv
// Shared definitions for the AXI-Stream to BRAM writer: FSM encoding and
// default parameter values.
package axis_bram_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_LEN_WIDTH  = 16;

endpackage

// File: rtl/axis_bram_writer_if.sv
// Stream input and BRAM write port of the writer bundled as one interface.
// Handshake: a beat moves on a rising edge where tvalid and tready are both high.
interface axis_bram_writer_if
    import axis_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;
    logic                    bram_en;
    logic [DATA_WIDTH/8-1:0] bram_we;
    logic [ADDR_WIDTH-1:0]   bram_addr;
    logic [DATA_WIDTH-1:0]   bram_din;

    modport master (
        output tdata, tvalid, tlast,
        input  tready, bram_en, bram_we, bram_addr, bram_din
    );

    modport slave (
        input  tdata, tvalid, tlast,
        output tready, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/axis_bram_writer.sv
// Writes a length-bounded AXI-Stream packet into consecutive BRAM words,
// flagging packets that end too early or too late.
module axis_bram_writer
    import axis_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0]    length,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                    S_AXIS_TVALID,
    input  logic                    S_AXIS_TLAST,
    output logic                    S_AXIS_TREADY,
    output logic                    BRAM_EN,
    output logic [DATA_WIDTH/8-1:0] BRAM_WE,
    output logic [ADDR_WIDTH-1:0]   BRAM_ADDR,
    output logic [DATA_WIDTH-1:0]   BRAM_DIN,
    output logic                    busy,
    output logic                    done,
    output logic                    err_early,
    output logic                    err_late,
    output logic [LEN_WIDTH-1:0]    word_count,
    output state_t                  dbg_state
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  next_count;
    logic                  last_word;

    assign next_count    = word_count + LEN_WIDTH'(1);
    assign last_word     = (next_count == len_q);
    // Ready is decoded from state so reset drops it in the same instant.
    assign S_AXIS_TREADY = (state == S_RUN) || (state == S_DRAIN);
    assign dbg_state     = state;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
            BRAM_EN    <= 1'b0;
            BRAM_WE    <= '0;
            BRAM_ADDR  <= '0;
            BRAM_DIN   <= '0;
        end else begin
            done    <= 1'b0;
            BRAM_EN <= 1'b0;
            BRAM_WE <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            base_q     <= base_addr;
                            len_q      <= length;
                            word_count <= '0;
                            err_early  <= 1'b0;
                            err_late   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= S_RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (S_AXIS_TVALID) begin
                        BRAM_EN    <= 1'b1;
                        BRAM_WE    <= '1;
                        BRAM_ADDR  <= base_q + ADDR_WIDTH'(word_count);
                        BRAM_DIN   <= S_AXIS_TDATA;
                        word_count <= next_count;
                        if (last_word) begin
                            if (S_AXIS_TLAST) begin
                                state <= S_FINISH;
                            end else begin
                                err_late <= 1'b1;
                                state    <= S_DRAIN;
                            end
                        end else if (S_AXIS_TLAST) begin
                            err_early <= 1'b1;
                            state     <= S_FINISH;
                        end
                    end
                end
                // Surplus beats are swallowed so the DMA can finish its packet.
                S_DRAIN: begin
                    if (S_AXIS_TVALID && S_AXIS_TLAST) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
